// File: rtl/f_pkg.sv
// rtl/f_pkg.sv - shared constants, state encoding and helper types for the binary32 multiplier
package f_pkg;

  localparam int          BIAS      = 127;
  localparam logic [31:0] CANON_NAN = 32'h7FC00000;
  localparam logic [31:0] POS_INF   = 32'h7F800000;

  // Bit positions inside the classifier's 5-bit class vector
  localparam int CLS_NAN  = 4;
  localparam int CLS_INF  = 3;
  localparam int CLS_SUB  = 2;
  localparam int CLS_ZERO = 1;
  localparam int CLS_NORM = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL   = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } flags_t;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
  } cls_t;

  // An all-zero class vector is non-canonical and is treated as NaN; subnormals read as zero
  function automatic cls_t decode_cls(input logic [4:0] cls);
    cls_t r;
    r.nan  = cls[CLS_NAN] | (cls == 5'd0);
    r.inf  = cls[CLS_INF] & ~r.nan;
    r.zero = (cls[CLS_SUB] | cls[CLS_ZERO]) & ~r.nan;
    return r;
  endfunction

endpackage

// File: rtl/f_mant_mul_iter.sv
// rtl/f_mant_mul_iter.sv - iterative 24x24 shift-add mantissa multiplier, BITS_PER_CYCLE bits per step
module f_mant_mul_iter #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] a_mant,
  input  logic [23:0] b_mant,
  output logic        busy,
  output logic        done,
  output logic [47:0] product
);

  localparam int STEPS = 24 / BITS_PER_CYCLE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic [47:0]   mcand;
  logic [23:0]   mplier;
  logic [47:0]   acc;
  logic [CW-1:0] cnt;
  logic [47:0]   partial;

  always_comb begin
    partial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier[i]) partial = partial + (mcand << i);
    end
  end

  assign done    = busy && (cnt == CW'(STEPS - 1));
  assign product = acc;

  // Multiplicand walks left and multiplier walks right so each step only sees its low bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= {24'd0, a_mant};
      mplier <= b_mant;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc + partial;
      mcand  <= mcand << BITS_PER_CYCLE;
      mplier <= mplier >> BITS_PER_CYCLE;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/f_mul_seq.sv
// rtl/f_mul_seq.sv - iterative binary32 multiplier with class-flag special cases, RNE, FTZ/DAZ
module f_mul_seq
  import f_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  a_cls,
  input  logic [4:0]  b_cls,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic [3:0]  flags
);

  localparam logic signed [9:0] BIAS10 = 10'(BIAS);

  state_t state, state_nxt;

  logic               sign_r;
  logic signed [9:0]  exp_r;
  logic [23:0]        mant_r;
  logic               guard_r;
  logic               sticky_r;
  logic [31:0]        y_r;
  flags_t             flags_r;

  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [47:0]        product;

  // ---------------------------------------------------------------- special-case decode
  cls_t               ca, cb;
  logic               sgn;
  logic               is_special;
  logic [31:0]        spec_y;
  flags_t             spec_flags;
  logic signed [9:0]  exp_sum;

  assign ca      = decode_cls(a_cls);
  assign cb      = decode_cls(b_cls);
  assign sgn     = a[31] ^ b[31];
  assign exp_sum = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - BIAS10;

  assign is_special = ca.nan | cb.nan | ca.inf | cb.inf | ca.zero | cb.zero;

  always_comb begin
    spec_y     = {sgn, 31'd0};
    spec_flags = '0;
    if (ca.nan || cb.nan) begin
      spec_y = CANON_NAN;
    end else if ((ca.inf || cb.inf) && (ca.zero || cb.zero)) begin
      spec_y             = CANON_NAN;
      spec_flags.invalid = 1'b1;
    end else if (ca.inf || cb.inf) begin
      spec_y = {sgn, POS_INF[30:0]};
    end
  end

  assign accept    = in_valid & in_ready;
  assign mul_start = accept & ~is_special;

  f_mant_mul_iter #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_mant_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mul_start),
    .a_mant ({1'b1, a[22:0]}),
    .b_mant ({1'b1, b[22:0]}),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(product)
  );

  // ---------------------------------------------------------------- normalise
  logic               norm_shift;
  logic [23:0]        mant_n;
  logic               guard_n;
  logic               sticky_n;
  logic signed [9:0]  exp_n;

  // Product of two [1,2) mantissas lies in [1,4); bit 47 flags the [2,4) half
  always_comb begin
    norm_shift = product[47];
    if (norm_shift) begin
      mant_n   = product[47:24];
      guard_n  = product[23];
      sticky_n = |product[22:0];
    end else begin
      mant_n   = product[46:23];
      guard_n  = product[22];
      sticky_n = |product[21:0];
    end
    exp_n = exp_r + $signed({9'd0, norm_shift});
  end

  // ---------------------------------------------------------------- round (RNE) and range check
  logic               round_up;
  logic [24:0]        mant_sum;
  logic signed [9:0]  exp_rnd;
  logic [31:0]        rnd_y;
  flags_t             rnd_flags;

  always_comb begin
    round_up  = guard_r & (sticky_r | mant_r[0]);
    mant_sum  = {1'b0, mant_r} + {24'd0, round_up};
    exp_rnd   = exp_r + $signed({9'd0, mant_sum[24]});
    rnd_flags = '0;
    rnd_flags.inexact = guard_r | sticky_r;
    if (mant_sum[24]) begin
      rnd_y = {sign_r, exp_rnd[7:0], mant_sum[23:1]};
    end else begin
      rnd_y = {sign_r, exp_rnd[7:0], mant_sum[22:0]};
    end
    if (exp_rnd >= 10'sd255) begin
      rnd_y              = {sign_r, POS_INF[30:0]};
      rnd_flags.overflow = 1'b1;
      rnd_flags.inexact  = 1'b1;
    end else if (exp_rnd <= 10'sd0) begin
      rnd_y               = {sign_r, 31'd0};
      rnd_flags.underflow = 1'b1;
      rnd_flags.inexact   = 1'b1;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = is_special ? DONE : MUL;
      MUL:     if (mul_done) state_nxt = NORM;
      NORM:    state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // ---------------------------------------------------------------- datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r   <= 1'b0;
      exp_r    <= '0;
      mant_r   <= '0;
      guard_r  <= 1'b0;
      sticky_r <= 1'b0;
      y_r      <= '0;
      flags_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sign_r <= sgn;
            exp_r  <= exp_sum;
            if (is_special) begin
              y_r     <= spec_y;
              flags_r <= spec_flags;
            end
          end
        end
        NORM: begin
          mant_r   <= mant_n;
          guard_r  <= guard_n;
          sticky_r <= sticky_n;
          exp_r    <= exp_n;
        end
        ROUND: begin
          y_r     <= rnd_y;
          flags_r <= rnd_flags;
        end
        default: ;
      endcase
    end
  end

  assign y     = y_r;
  assign flags = flags_r;

  // mul_busy is only observed for debug visibility on the hierarchy
  logic unused_busy;
  assign unused_busy = mul_busy;

endmodule

// File: tb/tb_f_mul_seq.sv
// tb/tb_f_mul_seq.sv - scoreboard-driven self-checking bench for f_mul_seq
module tb_f_mul_seq;

  localparam logic [4:0] C_NAN  = 5'b10000;
  localparam logic [4:0] C_INF  = 5'b01000;
  localparam logic [4:0] C_SUB  = 5'b00100;
  localparam logic [4:0] C_ZERO = 5'b00010;
  localparam logic [4:0] C_NORM = 5'b00001;
  localparam int         FIN_LAT = 27;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  a_cls = '0;
  logic [4:0]  b_cls = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] y;
  logic [3:0]  flags;

  typedef struct {
    logic [31:0] y;
    logic [3:0]  f;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  f_mul_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .a_cls    (a_cls),
    .b_cls    (b_cls),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .flags    (flags)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] cls_of(input logic [31:0] x);
    if (x[30:23] == 8'hFF) return (x[22:0] != 0) ? C_NAN : C_INF;
    if (x[30:23] == 8'h00) return (x[22:0] != 0) ? C_SUB : C_ZERO;
    return C_NORM;
  endfunction

  // Reference for normal*normal with in-range result: exact 48-bit product, then RNE
  function automatic exp_t model_mul(input logic [31:0] x, input logic [31:0] z);
    exp_t        r;
    logic [63:0] p, q, rem, half;
    int          e, sh;
    p    = 64'({1'b1, x[22:0]}) * 64'({1'b1, z[22:0]});
    sh   = p[47] ? 24 : 23;
    e    = int'(x[30:23]) + int'(z[30:23]) - 127 + (p[47] ? 1 : 0);
    q    = p >> sh;
    rem  = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    if (q[24]) begin
      q = q >> 1;
      e = e + 1;
    end
    r.y   = {x[31] ^ z[31], e[7:0], q[22:0]};
    r.f   = {3'b000, rem != 0};
    r.lat = FIN_LAT;
    return r;
  endfunction

  // Push expectation, present the operands and hold until the accept edge
  task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic [4:0] ca,
                       input logic [4:0] cb, input logic [31:0] ey, input logic [3:0] ef,
                       input int elat);
    exp_t e;
    int   n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      $display("FAIL issue_timeout in_ready=%b required=1", in_ready);
      miscompares++;
    end
    e.y = ey; e.f = ef; e.lat = elat;
    exp_q.push_back(e);
    a = va; b = vb; a_cls = ca; b_cls = cb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; a_cls = 5'($urandom); b_cls = 5'($urandom);
    vectors++;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== 32'h0 || flags !== 4'h0) begin
      $display("FAIL reset_values out_valid=%b in_ready=%b y=%h flags=%b required 0/1/00000000/0000",
               out_valid, in_ready, y, flags);
      miscompares++;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL post_reset_idle out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      miscompares++;
    end
  endtask

  task automatic test_specials();
    logic [31:0] va, vb, ey;
    logic [4:0]  ca, cb;
    logic [3:0]  ef;
    int          lat;
    exp_t        e;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: begin va = 32'h7F800000; vb = 32'h00000000; ca = C_INF;  cb = C_ZERO; ey = 32'h7FC00000; ef = 4'b1000; end
        1: begin va = 32'h7FC00001; vb = 32'h3F800000; ca = C_NAN;  cb = C_NORM; ey = 32'h7FC00000; ef = 4'b0000; end
        2: begin va = 32'hFF800000; vb = 32'h40000000; ca = C_INF;  cb = C_NORM; ey = 32'hFF800000; ef = 4'b0000; end
        3: begin va = 32'h80000000; vb = 32'h3F800000; ca = C_ZERO; cb = C_NORM; ey = 32'h80000000; ef = 4'b0000; end
        4: begin va = 32'h00000001; vb = 32'hBF800000; ca = C_SUB;  cb = C_NORM; ey = 32'h80000000; ef = 4'b0000; end
        5: begin va = 32'h3F800000; vb = 32'h40000000; ca = 5'b0;   cb = C_NORM; ey = 32'h7FC00000; ef = 4'b0000; end
        6: begin va = 32'h00000001; vb = 32'hFF800000; ca = C_SUB;  cb = C_INF;  ey = 32'h7FC00000; ef = 4'b1000; end
        default: begin va = 32'hFF800000; vb = 32'hC0000000; ca = C_INF; cb = C_NORM; ey = 32'h7F800000; ef = 4'b0000; end
      endcase
      issue(va, vb, ca, cb, ey, ef, 1);
      wait_out(lat);
      e = exp_q.pop_front();
      if (y !== e.y || flags !== e.f || lat != e.lat || out_valid !== 1'b1) begin
        $display("FAIL special_%0d y=%h flags=%b lat=%0d required y=%h flags=%b lat=%0d",
                 i, y, flags, lat, e.y, e.f, e.lat);
        miscompares++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_finite();
    logic [31:0] va, vb, ey;
    logic [3:0]  ef;
    int          lat;
    exp_t        e;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin va = 32'h3FC00000; vb = 32'h40000000; ey = 32'h40400000; ef = 4'b0000; end
        1: begin va = 32'h3F800001; vb = 32'h3F800001; ey = 32'h3F800002; ef = 4'b0001; end
        2: begin va = 32'h7F000000; vb = 32'h40000000; ey = 32'h7F800000; ef = 4'b0101; end
        3: begin va = 32'h00800000; vb = 32'h3F000000; ey = 32'h00000000; ef = 4'b0011; end
        4: begin va = 32'hBFC00000; vb = 32'h40000000; ey = 32'hC0400000; ef = 4'b0000; end
        5: begin va = 32'hFF000000; vb = 32'h40000000; ey = 32'hFF800000; ef = 4'b0101; end
        default: begin va = 32'h3FFFFFFF; vb = 32'h3FFFFFFF; ey = 32'h407FFFFE; ef = 4'b0001; end
      endcase
      issue(va, vb, C_NORM, C_NORM, ey, ef, FIN_LAT);
      wait_out(lat);
      e = exp_q.pop_front();
      if (y !== e.y || flags !== e.f || lat != e.lat || out_valid !== 1'b1) begin
        $display("FAIL finite_%0d y=%h flags=%b lat=%0d required y=%h flags=%b lat=%0d",
                 i, y, flags, lat, e.y, e.f, e.lat);
        miscompares++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va, vb;
    exp_t        m, e;
    int          lat;
    for (int i = 0; i < 16; i++) begin
      va = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
      vb = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
      m  = model_mul(va, vb);
      issue(va, vb, cls_of(va), cls_of(vb), m.y, m.f, m.lat);
      wait_out(lat);
      e = exp_q.pop_front();
      if (y !== e.y || flags !== e.f || lat != e.lat) begin
        $display("FAIL random_%0d a=%h b=%h y=%h flags=%b lat=%0d required y=%h flags=%b lat=%0d",
                 i, va, vb, y, flags, lat, e.y, e.f, e.lat);
        miscompares++;
      end
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        $display("FAIL random_%0d_release out_valid=%b in_ready=%b required 0/1", i, out_valid, in_ready);
        miscompares++;
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   lat;
    int   bad = 0;
    out_ready = 1'b0;
    issue(32'h3FC00000, 32'h40000000, C_NORM, C_NORM, 32'h40400000, 4'b0000, FIN_LAT);
    wait_out(lat);
    e = exp_q.pop_front();
    if (y !== e.y || flags !== e.f || lat != e.lat) begin
      $display("FAIL backpressure_result y=%h flags=%b lat=%0d required y=%h flags=%b lat=%0d",
               y, flags, lat, e.y, e.f, e.lat);
      miscompares++;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (y !== e.y || flags !== e.f || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    if (bad != 0) begin
      $display("FAIL backpressure_hold unstable_cycles=%0d required 0 (y=%h out_valid=%b in_ready=%b)",
               bad, y, out_valid, in_ready);
      miscompares++;
    end
    // Present a new op during the handshake edge: it must not be taken that same cycle
    a = 32'hFF800000; b = 32'h40000000; a_cls = C_INF; b_cls = C_NORM;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL handshake_release out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      miscompares++;
    end
    e.y = 32'hFF800000; e.f = 4'b0000; e.lat = 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    e = exp_q.pop_front();
    if (out_valid !== 1'b1 || y !== e.y || flags !== e.f) begin
      $display("FAIL reaccept_next_cycle out_valid=%b y=%h flags=%b required 1/%h/%b",
               out_valid, y, flags, e.y, e.f);
      miscompares++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   lat;
    int   seen = 0;
    issue(32'h40400000, 32'h40400000, C_NORM, C_NORM, 32'h41100000, 4'b0000, FIN_LAT);
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== 32'h0 || flags !== 4'h0) begin
      $display("FAIL midop_reset_values out_valid=%b in_ready=%b y=%h flags=%b required 0/1/00000000/0000",
               out_valid, in_ready, y, flags);
      miscompares++;
    end
    void'(exp_q.pop_front());
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    if (seen != 0) begin
      $display("FAIL midop_discard out_valid_cycles=%0d required 0", seen);
      miscompares++;
    end
    issue(32'h3FC00000, 32'h40000000, C_NORM, C_NORM, 32'h40400000, 4'b0000, FIN_LAT);
    wait_out(lat);
    e = exp_q.pop_front();
    if (y !== e.y || flags !== e.f || lat != e.lat) begin
      $display("FAIL after_reset_op y=%h flags=%b lat=%0d required y=%h flags=%b lat=%0d",
               y, flags, lat, e.y, e.f, e.lat);
      miscompares++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_specials();
    test_finite();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain left=%0d required 0", exp_q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
